// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC sequencer feeding a 2-entry {pc, ins} queue toward the decoder.
// Optional FETCH_MISALIGN_TRAP_EN traps misaligned redirects into a sticky FAULT state.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int unsigned IMEM_BYTES = 80
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_ins,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ins,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;

  localparam logic [32:0] LIMIT = 33'(IMEM_BYTES);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] q0_pc, q0_ins, q1_pc, q1_ins;
  logic [1:0]  count;

  logic [31:0] redir_tgt;
  logic        misalign;
  logic        redir;
  logic        pop;
  logic        pc_ok;
  logic        tgt_ok;
  logic        do_fetch;
  logic        to_halt;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redir_tgt = redirect_pc;
  assign misalign  = redirect_pc[1:0] != 2'b00;
`else
  assign redir_tgt = redirect_pc & ~32'h3;
  assign misalign  = 1'b0;
`endif

  assign imem_addr = pc;
  assign out_valid = count != 2'd0;
  assign out_pc    = q0_pc;
  assign out_ins   = q0_ins;

  // A word at address a is fetchable only if a+4 fits; 33-bit compare avoids wrap.
  assign pc_ok    = ({1'b0, pc} + 33'd4) <= LIMIT;
  assign tgt_ok   = ({1'b0, redir_tgt} + 33'd4) <= LIMIT;
  assign redir    = redirect_valid && (state != FAULT);
  assign pop      = out_valid && out_ready;
  assign do_fetch = (state == RUN) && pc_ok && ((count != 2'd2) || pop);
  assign to_halt  = (state == RUN) && !pc_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      pc     <= RESET_PC;
      count  <= '0;
      q0_pc  <= '0;
      q0_ins <= '0;
      q1_pc  <= '0;
      q1_ins <= '0;
      halted <= 1'b0;
      fault  <= 1'b0;
    end else if (redir) begin
      // Redirect wins over both fetch and pop: queue flushed, nothing pushed.
      count <= '0;
      if (misalign) begin
        state  <= FAULT;
        fault  <= 1'b1;
        halted <= 1'b0;
      end else begin
        pc <= redir_tgt;
        if (tgt_ok) begin
          state  <= RUN;
          halted <= 1'b0;
        end else begin
          state  <= HALT;
          halted <= 1'b1;
        end
      end
    end else begin
      if (to_halt) begin
        state  <= HALT;
        halted <= 1'b1;
      end
      if (do_fetch) pc <= pc + 32'd4;
      case ({do_fetch, pop})
        2'b10: begin
          if (count == 2'd0) begin
            q0_pc  <= pc;
            q0_ins <= imem_ins;
          end else begin
            q1_pc  <= pc;
            q1_ins <= imem_ins;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          q0_pc  <= q1_pc;
          q0_ins <= q1_ins;
          count  <= count - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged: the incoming word lands behind whatever remains.
          if (count == 2'd1) begin
            q0_pc  <= pc;
            q0_ins <= imem_ins;
          end else begin
            q0_pc  <= q1_pc;
            q0_ins <= q1_ins;
            q1_pc  <= pc;
            q1_ins <= imem_ins;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0, the byte address fetched first after reset.
REQ-002 SHALL have parameter IMEM_BYTES, default 80, the instruction memory size in bytes (multiple of 4).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port imem_addr, output, 32 bits: byte address driven to the instruction memory, equal to the current PC.
REQ-006 SHALL have port imem_ins, input, 32 bits: little-endian word returned combinationally for imem_addr.
REQ-007 SHALL have port out_valid, output, 1 bit: the queue head is valid.
REQ-008 SHALL have port out_ready, input, 1 bit: the decoder accepts the head.
REQ-009 SHALL have port out_ins, output, 32 bits: head instruction.
REQ-010 SHALL have port out_pc, output, 32 bits: byte address of the head instruction.
REQ-011 SHALL have port redirect_valid, input, 1 bit: a branch or jump redirect request.
REQ-012 SHALL have port redirect_pc, input, 32 bits: redirect target byte address.
REQ-013 SHALL have port halted, output, 1 bit: the fetch PC has passed the end of memory.
REQ-014 SHALL have port fault, output, 1 bit: a misaligned redirect was trapped (see Configuration).

Function
REQ-015 SHALL implement states RUN, HALT and FAULT, plus a 2-entry {pc, ins} FIFO.
REQ-016 In RUN, SHALL fetch when FIFO not full, or full with pop this cycle: push {pc, imem_ins} and advance pc by 4.
REQ-017 Handshake: pop occurs when out_valid && out_ready; head order equals fetch order; out_* hold stable while out_valid && !out_ready.
REQ-018 Latency: a word fetched in cycle N SHALL appear on out_* no earlier than cycle N+1 (registered FIFO, no bypass).
REQ-019 SHALL transition RUN->HALT when a fetch would address pc+4 > IMEM_BYTES; HALT performs no fetch, drains the FIFO, and asserts halted.
REQ-020 Redirect SHALL take priority over fetch and pop in the same cycle: FIFO flushed, pc <= redirect_pc, no push that cycle, out_valid=0 next cycle.
REQ-021 A redirect in HALT with an in-range target SHALL return to RUN; an out-of-range target SHALL remain in HALT with an empty FIFO.
REQ-022 Simultaneous push and pop on a full FIFO SHALL keep occupancy at 2, with no loss or duplication.
REQ-023 PC arithmetic SHALL be 32-bit unsigned; wrap past 2^32 is not reachable because of REQ-019.

Reset
REQ-024 rst_n low SHALL asynchronously force state=RUN, pc=RESET_PC, FIFO empty, out_valid=0, out_ins=0, out_pc=0, halted=0, fault=0.
REQ-025 Reset asserted mid-operation SHALL discard FIFO contents and any pending redirect; the first fetch SHALL occur in the first clock after rst_n deasserts.

Configuration
REQ-026 With macro FETCH_MISALIGN_TRAP_EN defined, a redirect with redirect_pc[1:0] != 0 SHALL flush the FIFO, enter FAULT, assert fault, and stop fetching until reset.
REQ-027 Without FETCH_MISALIGN_TRAP_EN, redirect_pc[1:0] SHALL be forced to 0, fault SHALL be tied to 0, and FAULT SHALL be unreachable.

Verification
REQ-028 Reset, out_ready=1, memory preloaded (addi x1,5 / addi x2,9 / add / sw) -> out_pc 0,4,8,12 with out_ins 00500093, 00900113, 002080B3, 0020A4A3 on consecutive cycles.
REQ-029 out_ready=0 for 4 cycles after reset -> FIFO holds pc 0 and 4, imem_addr stays 8, out_pc=0 stable; on release, out_pc 0,4,8 follow back-to-back.
REQ-030 FIFO full (pc 0,4), redirect_valid=1 with redirect_pc=12 and out_ready=1 in the same cycle -> no pop counted, out_valid=0 next cycle, then out_pc=12 with ins 0020A4A3.
REQ-031 IMEM_BYTES=80, out_ready=1 -> last out_pc=76, halted=1 once pc=80, out_valid=0 after drain; redirect to 0 -> halted=0 and out_pc=0 reappears.
REQ-032 redirect_pc=6 -> with FETCH_MISALIGN_TRAP_EN: fault=1, out_valid stays 0 until rst_n pulse; without it: next out_pc=4.
REQ-033 rst_n pulsed low asynchronously mid-stream at pc=8 -> outputs zero immediately, then out_pc=0 is the first output after release.
